// File: rtl/ifm_bank_loader_pkg.sv
// Shared geometry, state encoding and write-port payload for the IFM bank loader.
package ifm_bank_loader_pkg;

  localparam int unsigned NUM_BANKS      = 16;
  localparam int unsigned WORDS_PER_BANK = 128;
  localparam int unsigned ADDR_W         = 9;
  localparam int unsigned LINE_W         = 128;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned NUM_BIAS       = 4;
  localparam int unsigned BIAS_W         = 16;

  localparam int unsigned BANK_IDX_W = $clog2(NUM_BANKS);
  localparam int unsigned WORD_IDX_W = $clog2(WORDS_PER_BANK);
  localparam int unsigned BIAS_CNT_W = $clog2(NUM_BIAS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BIAS = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } loader_state_e;

  // One BRAM write beat; wea always mirrors ena so only ena is carried.
  typedef struct packed {
    logic [NUM_BANKS-1:0] ena;
    logic [ADDR_W-1:0]    addr;
    logic [LINE_W-1:0]    dia;
  } bram_wr_t;

  function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [BANK_IDX_W-1:0] idx);
    return NUM_BANKS'(1) << idx;
  endfunction

endpackage

// File: rtl/ifm_bank_loader_if.sv
// Stream input and BRAM write port of the loader grouped as one bundle.
interface ifm_bank_loader_if;
  import ifm_bank_loader_pkg::*;

  logic                 i_s_valid;
  logic [WORD_W-1:0]    i_s_data;
  logic                 o_s_ready;
  logic [NUM_BANKS-1:0] o_ena;
  logic [NUM_BANKS-1:0] o_wea;
  logic [ADDR_W-1:0]    o_addra;
  logic [LINE_W-1:0]    o_dia;

  // Loader side.
  modport slave (
    input  i_s_valid, i_s_data,
    output o_s_ready, o_ena, o_wea, o_addra, o_dia
  );

  // Feeder / observer side.
  modport master (
    output i_s_valid, i_s_data,
    input  o_s_ready, o_ena, o_wea, o_addra, o_dia
  );
endinterface

// File: rtl/ifm_bank_loader_packer.sv
// Packs PACK stream words into one line; slot 0 lands in the low bits.
module line_packer
  import ifm_bank_loader_pkg::*;
#(
  parameter int unsigned PACK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_push,
  input  logic [WORD_W-1:0] i_data,
  output logic [LINE_W-1:0] o_line_c,
  output logic              o_last_c
);

  localparam int unsigned CNT_W  = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int unsigned PACK_W = WORD_W * PACK;

  logic [CNT_W-1:0]  r_cnt;
  logic [PACK_W-1:0] r_pack;
  logic [PACK_W-1:0] w_merged;

  // Line as it will look after the current push, so the last word is included.
  always_comb begin
    w_merged = r_pack;
    for (int unsigned s = 0; s < PACK; s++) begin
      if (i_push && (r_cnt == CNT_W'(s))) begin
        w_merged[s*WORD_W +: WORD_W] = i_data;
      end
    end
  end

  assign o_last_c = i_push && (r_cnt == CNT_W'(PACK - 1));
  assign o_line_c = LINE_W'(w_merged);

  // Slot counter and pack register; both hold while no word arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_pack <= '0;
    end else if (i_clear) begin
      r_cnt  <= '0;
      r_pack <= '0;
    end else if (i_push) begin
      r_pack <= w_merged;
      r_cnt  <= o_last_c ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ifm_bank_loader.sv
// Captures bias words, then packs IFM pixels into lines written across the BRAM banks.
module ifm_bank_loader
  import ifm_bank_loader_pkg::*;
#(
  parameter int unsigned PACK = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  ifm_bank_loader_if.slave   io_bus,
  output logic [BIAS_W-1:0]  o_bias0,
  output logic [BIAS_W-1:0]  o_bias1,
  output logic [BIAS_W-1:0]  o_bias2,
  output logic [BIAS_W-1:0]  o_bias3,
  output logic               o_busy,
  output logic               o_layer_start
);

  loader_state_e r_state;
  loader_state_e w_state_next;

  logic                  w_hs;
  logic                  w_push;
  logic                  w_clear;
  logic                  w_write;
  logic                  w_last;
  logic                  w_ready_next;
  logic [LINE_W-1:0]     w_line;

  logic [BIAS_CNT_W-1:0] r_bias_cnt;
  logic [WORD_IDX_W-1:0] r_addr_cnt;
  logic [BANK_IDX_W-1:0] r_bank_idx;
  logic [BIAS_W-1:0]     r_bias [NUM_BIAS];
  bram_wr_t              r_wr;
  logic                  r_s_ready;
  logic                  r_busy;
  logic                  r_layer_start;

  assign w_hs   = io_bus.i_s_valid & r_s_ready;
  assign w_push = w_hs && (r_state == ST_FILL);

  line_packer #(.PACK(PACK)) u_packer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_push   (w_push),
    .i_data   (io_bus.i_s_data),
    .o_line_c (w_line),
    .o_last_c (w_last)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, load/clear and write decisions.
  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_write      = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_load) begin
          w_state_next = ST_BIAS;
          w_clear      = 1'b1;
        end
      end
      ST_BIAS: begin
        if (w_hs && (r_bias_cnt == BIAS_CNT_W'(NUM_BIAS - 1))) begin
          w_state_next = ST_FILL;
        end
      end
      ST_FILL: begin
        if (w_last) begin
          w_write = 1'b1;
          if ((r_bank_idx == BANK_IDX_W'(NUM_BANKS - 1)) &&
              (r_addr_cnt == WORD_IDX_W'(WORDS_PER_BANK - 1))) begin
            w_state_next = ST_DONE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    // Stream is closed for the write cycle so a line never overlaps its write.
    w_ready_next = (w_state_next == ST_BIAS) ||
                   ((w_state_next == ST_FILL) && !w_write);
  end

  // Counters, bias capture and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bias_cnt    <= '0;
      r_addr_cnt    <= '0;
      r_bank_idx    <= '0;
      for (int i = 0; i < NUM_BIAS; i++) r_bias[i] <= '0;
      r_wr          <= '0;
      r_s_ready     <= 1'b0;
      r_busy        <= 1'b0;
      r_layer_start <= 1'b0;
    end else begin
      r_s_ready     <= w_ready_next;
      r_busy        <= (w_state_next == ST_BIAS) || (w_state_next == ST_FILL);
      r_layer_start <= (r_state == ST_DONE) && (w_state_next == ST_DONE);
      r_wr.ena      <= w_write ? bank_onehot(r_bank_idx) : '0;

      if (w_clear) begin
        r_bias_cnt <= '0;
        r_addr_cnt <= '0;
        r_bank_idx <= '0;
        for (int i = 0; i < NUM_BIAS; i++) r_bias[i] <= '0;
      end

      if (w_hs && (r_state == ST_BIAS)) begin
        r_bias[r_bias_cnt] <= io_bus.i_s_data[BIAS_W-1:0];
        r_bias_cnt         <= r_bias_cnt + BIAS_CNT_W'(1);
      end

      if (w_write) begin
        r_wr.addr <= ADDR_W'(r_addr_cnt);
        r_wr.dia  <= w_line;
        if (r_addr_cnt == WORD_IDX_W'(WORDS_PER_BANK - 1)) begin
          r_addr_cnt <= '0;
          r_bank_idx <= r_bank_idx + BANK_IDX_W'(1);
        end else begin
          r_addr_cnt <= r_addr_cnt + WORD_IDX_W'(1);
        end
      end
    end
  end

  assign io_bus.o_s_ready = r_s_ready;
  assign io_bus.o_ena     = r_wr.ena;
  assign io_bus.o_wea     = r_wr.ena;
  assign io_bus.o_addra   = r_wr.addr;
  assign io_bus.o_dia     = r_wr.dia;
  assign o_bias0          = r_bias[0];
  assign o_bias1          = r_bias[1];
  assign o_bias2          = r_bias[2];
  assign o_bias3          = r_bias[3];
  assign o_busy           = r_busy;
  assign o_layer_start    = r_layer_start;

endmodule
